// File: rtl/lfsr_checker.sv
// lfsr_checker: acquires, tracks and error-counts a 16-bit Fibonacci LFSR word stream
module lfsr_checker #(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        clear_errs,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count
);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_t;
  state_t      state, state_n;
  logic [15:0] expected, expected_n;
  logic [3:0]  match_cnt, match_n, miss_cnt, miss_n;
  logic        err;
  function automatic logic [15:0] nxt(input logic [15:0] w);
    return {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
  endfunction
  // next-state: seed in HUNT, confirm in VERIFY, free-run and count misses in LOCK
  always_comb begin
    state_n    = state;
    expected_n = expected;
    match_n    = match_cnt;
    miss_n     = miss_cnt;
    err        = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: if (in_data != 16'd0) begin
          expected_n = nxt(in_data);
          match_n    = 4'd0;
          state_n    = VERIFY;
        end
        VERIFY: if (in_data == 16'd0) begin
          state_n = HUNT;
          match_n = 4'd0;
        end else if (in_data == expected) begin
          expected_n = nxt(in_data);
          match_n    = match_cnt + 4'd1;
          state_n    = (match_n == 4'(LOCK_COUNT)) ? LOCK : VERIFY;
        end else begin
          expected_n = nxt(in_data);
          match_n    = 4'd0;
        end
        LOCK: begin
          expected_n = nxt(expected);
          err        = in_data != expected;
          miss_n     = err ? miss_cnt + 4'd1 : 4'd0;
          if (miss_n == 4'(UNLOCK_COUNT)) begin
            state_n = HUNT;
            miss_n  = 4'd0;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end
  // state and registered outputs; clear_errs only touches the counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      expected  <= 16'd0;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= 16'd0;
    end else begin
      state     <= state_n;
      expected  <= expected_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      locked    <= state_n == LOCK;
      err_pulse <= err;
      err_count <= clear_errs ? {15'd0, err} : (err && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
    end
  end
endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter: LOCK_COUNT, default 4, consecutive matching words needed to declare lock (legal 1..15).
REQ-002 Parameter: UNLOCK_COUNT, default 3, consecutive mismatching words while locked needed to drop lock (legal 1..15).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  in_data carries a sequence word this cycle.
REQ-006 Port: in_data  input  16  received LFSR word.
REQ-007 Port: clear_errs  input  1  synchronous clear of err_count.
REQ-008 Port: locked  output  1  registered; checker synchronized to the sequence.
REQ-009 Port: err_pulse  output  1  registered; one-cycle pulse per mismatching word while locked.
REQ-010 Port: err_count  output  16  registered; saturating count of mismatches while locked.

Function
REQ-011 The sequence checked SHALL be the 16-bit Fibonacci LFSR: next(w) = {w[14:0], w[15]^w[13]^w[12]^w[10]}.
REQ-012 Cycles with in_valid=0 SHALL change no state and no output except err_pulse, which deasserts.
REQ-013 States SHALL be HUNT, VERIFY and LOCK, held in an internal register expected[15:0] with 4-bit match_cnt and miss_cnt.
REQ-014 HUNT, valid, in_data!=0: expected <= next(in_data), match_cnt <= 0, go to VERIFY.
REQ-015 HUNT, valid, in_data==0: ignored (all-zero lockup word); stay in HUNT.
REQ-016 VERIFY, valid, in_data==expected: expected <= next(in_data), match_cnt +1; on the LOCK_COUNT-th consecutive match go to LOCK and set locked=1 at that edge.
REQ-017 VERIFY, valid, mismatch, in_data!=0: reseed with expected <= next(in_data), match_cnt <= 0, stay in VERIFY.
REQ-018 VERIFY, valid, in_data==0: go to HUNT, match_cnt <= 0.
REQ-019 LOCK, any valid word: expected <= next(expected), free-running and never reseeded from input, so a single corrupted word produces exactly one error.
REQ-020 LOCK, match: miss_cnt <= 0.
REQ-021 LOCK, mismatch: err_pulse=1 the following cycle; err_count +1 saturating at 0xFFFF; miss_cnt +1.
REQ-022 LOCK, UNLOCK_COUNT-th consecutive mismatch: go to HUNT, locked <= 0, miss_cnt <= 0; that word still counts as an error.
REQ-023 Mismatches in HUNT and VERIFY SHALL never assert err_pulse or change err_count.
REQ-024 clear_errs: err_count <= 0; if an error increment occurs in the same cycle, err_count <= 1.
REQ-025 clear_errs SHALL affect neither state, locked nor err_pulse.
REQ-026 Latency: every output reflects a valid word at the clock edge that samples it, one cycle after presentation.

Reset
REQ-027 reset=1 at a rising edge: state HUNT, expected=0, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_count=0.
REQ-028 reset SHALL override in_valid and clear_errs in the same cycle; reset mid-lock SHALL drop lock at once and require full reacquisition.

Verification
REQ-029 Stream 0xACE1, 0x59C3, 0xB387 and two further successors, one per cycle -> locked=1 after the 5th word's edge (seed + 4 matches); err_count=0.
REQ-030 While locked, replace one word with its bit-0-flipped value -> err_pulse high exactly one cycle, err_count=1, locked stays 1, following correct words produce no error.
REQ-031 While locked, three consecutive wrong words -> err_count +3, locked=0 after the third, state HUNT; a correct stream then relocks after 5 words.
REQ-032 In HUNT, feed 0x0000 then a valid stream -> zero ignored, lock after 5 further words; in VERIFY, a 0x0000 word -> back to HUNT with no error counted.
REQ-033 err_count at 0xFFFF with another mismatch -> stays 0xFFFF; clear_errs coincident with a mismatch -> err_count=1.
REQ-034 Assert reset mid-lock with in_valid=1 and clear_errs=1 -> all outputs 0 the next cycle; gaps of in_valid=0 inside a stream -> lock and error behaviour identical to a gapless stream.
